// File: rtl/disp_arbiter.sv
// Round-robin arbiter that gives one of three sources the hex display.
// A winner keeps the display for at least HOLD_CYC cycles and is then re-arbitrated.
module disp_arbiter #(
    parameter int HOLD_CYC = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [15:0] din2,
    output logic [15:0] q_a,
    output logic [2:0]  gnt,
    output logic [1:0]  src,
    output logic        busy
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    src_q, src_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [15:0]   qa_q, qa_d;

    logic [1:0]    cand1, cand2, arbWin;
    logic          arbValid, doGrant;

    function automatic logic [1:0] nextIdx(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    function automatic logic [2:0] oneHot(input logic [1:0] k);
        logic [2:0] r;
        r = 3'b000;
        case (k)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] dinSel(input logic [1:0] k, input logic [15:0] d0,
                                           input logic [15:0] d1, input logic [15:0] d2);
        logic [15:0] r;
        r = 16'h0000;
        case (k)
            2'd0:    r = d0;
            2'd1:    r = d1;
            2'd2:    r = d2;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Search order starts just after the last winner, so the previous owner ranks last.
    always_comb begin
        cand1    = nextIdx(last_q);
        cand2    = nextIdx(cand1);
        arbValid = |req;
        arbWin   = last_q;
        if (req[cand1]) begin
            arbWin = cand1;
        end else if (req[cand2]) begin
            arbWin = cand2;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        src_d   = src_q;
        gnt_d   = gnt_q;
        qa_d    = qa_q;
        doGrant = 1'b0;

        case (state_q)
            IDLE: begin
                if (arbValid) begin
                    doGrant = 1'b1;
                end
            end
            OWN: begin
                if (cnt_q == CNT_LAST) begin
                    if (arbValid) begin
                        doGrant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        src_d   = 2'b11;
                        gnt_d   = 3'b000;
                    end
                end else begin
                    // An owner that drops its request keeps the slot but loses the grant.
                    cnt_d = cnt_q + 1'b1;
                    if (req[src_q]) begin
                        gnt_d = oneHot(src_q);
                        qa_d  = dinSel(src_q, din0, din1, din2);
                    end else begin
                        gnt_d = 3'b000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doGrant) begin
            state_d = OWN;
            cnt_d   = '0;
            last_d  = arbWin;
            src_d   = arbWin;
            gnt_d   = oneHot(arbWin);
            qa_d    = dinSel(arbWin, din0, din1, din2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd2;
            src_q   <= 2'b11;
            gnt_q   <= 3'b000;
            qa_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
            qa_q    <= qa_d;
        end
    end

    assign q_a  = qa_q;
    assign gnt  = gnt_q;
    assign src  = src_q;
    assign busy = (state_q == OWN);

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter with HOLD_CYC=4: each applied vector queues the
// outputs expected after the next edge, and a monitor pops and compares them.
module tb_disp_arbiter;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [1:0]  src;
        logic [15:0] qa;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] din0, din1, din2;
    logic [15:0] q_a;
    logic [2:0]  gnt;
    logic [1:0]  src;
    logic        busy;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   stepNum = 0;

    disp_arbiter #(.HOLD_CYC(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .din0 (din0),
        .din1 (din1),
        .din2 (din2),
        .q_a  (q_a),
        .gnt  (gnt),
        .src  (src),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int idx, input logic [15:0] act,
                               input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s pop %0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    // Inputs change on the falling edge; the expectation describes outputs after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] r, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [2:0] eGnt, input logic [1:0] eSrc,
                                 input logic [15:0] eQa, input logic eBusy);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        din0  = d0;
        din1  = d1;
        din2  = d2;
        e.gnt  = eGnt;
        e.src  = eSrc;
        e.qa   = eQa;
        e.busy = eBusy;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 2'd3, 16'h0000, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("gnt",  stepNum, {13'd0, gnt},  {13'd0, e.gnt});
            checkOutput("src",  stepNum, {14'd0, src},  {14'd0, e.src});
            checkOutput("q_a",  stepNum, q_a,           e.qa);
            checkOutput("busy", stepNum, {15'd0, busy}, {15'd0, e.busy});
            stepNum++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        din0  = 16'h0;
        din1  = 16'h0;
        din2  = 16'h0;

        // Reset held two cycles with every source requesting
        doReset();
        doReset();

        // Single source: live tracking, then retained past expiry with no gap
        applyStimulus(1'b0, 3'b001, 16'h1234, 16'h0, 16'h0, 3'b001, 2'd0, 16'h1234, 1'b1);
        applyStimulus(1'b0, 3'b001, 16'hABCD, 16'h0, 16'h0, 3'b001, 2'd0, 16'hABCD, 1'b1);
        applyStimulus(1'b0, 3'b001, 16'hABCD, 16'h0, 16'h0, 3'b001, 2'd0, 16'hABCD, 1'b1);
        applyStimulus(1'b0, 3'b001, 16'hABCD, 16'h0, 16'h0, 3'b001, 2'd0, 16'hABCD, 1'b1);
        applyStimulus(1'b0, 3'b001, 16'h5A5A, 16'h0, 16'h0, 3'b001, 2'd0, 16'h5A5A, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h9999, 16'h0, 16'h0, 3'b000, 2'd0, 16'h5A5A, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h9999, 16'h0, 16'h0, 3'b000, 2'd0, 16'h5A5A, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h9999, 16'h0, 16'h0, 3'b000, 2'd0, 16'h5A5A, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h9999, 16'h0, 16'h0, 3'b000, 2'd3, 16'h5A5A, 1'b0);

        // Full contention: owners rotate 0,1,2,0 for four cycles each
        doReset();
        for (int slot = 0; slot < 4; slot++) begin
            logic [1:0] own;
            own = (slot == 3) ? 2'd0 : 2'(slot);
            for (int c = 0; c < 4; c++) begin
                applyStimulus(1'b0, 3'b111, 16'h0001, 16'h0002, 16'h0003,
                              3'b001 << own, own, 16'(own) + 16'h0001, 1'b1);
            end
        end

        // Owner 1 drops early: grant clears, display freezes, then idle
        doReset();
        applyStimulus(1'b0, 3'b010, 16'h0, 16'hBEEF, 16'h0, 3'b010, 2'd1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h0, 16'h1111, 16'h0, 3'b000, 2'd1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h0, 16'h1111, 16'h0, 3'b000, 2'd1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h0, 16'h1111, 16'h0, 3'b000, 2'd1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 3'b000, 16'h0, 16'h1111, 16'h0, 3'b000, 2'd3, 16'hBEEF, 1'b0);

        // Owner 0 drops exactly on the expiry edge while source 2 waits
        doReset();
        applyStimulus(1'b0, 3'b001, 16'h0A0A, 16'h0, 16'h0C0C, 3'b001, 2'd0, 16'h0A0A, 1'b1);
        applyStimulus(1'b0, 3'b101, 16'h0A0A, 16'h0, 16'h0C0C, 3'b001, 2'd0, 16'h0A0A, 1'b1);
        applyStimulus(1'b0, 3'b101, 16'h0A0A, 16'h0, 16'h0C0C, 3'b001, 2'd0, 16'h0A0A, 1'b1);
        applyStimulus(1'b0, 3'b101, 16'h0A0A, 16'h0, 16'h0C0C, 3'b001, 2'd0, 16'h0A0A, 1'b1);
        applyStimulus(1'b0, 3'b100, 16'h0A0A, 16'h0, 16'h0C0C, 3'b100, 2'd2, 16'h0C0C, 1'b1);
        applyStimulus(1'b0, 3'b101, 16'h0A0A, 16'h0, 16'h0D0D, 3'b100, 2'd2, 16'h0D0D, 1'b1);

        // Reset while owner 1 is mid-dwell, then source 0 wins first
        doReset();
        applyStimulus(1'b0, 3'b010, 16'h0, 16'h5555, 16'h0, 3'b010, 2'd1, 16'h5555, 1'b1);
        applyStimulus(1'b0, 3'b010, 16'h0, 16'h5555, 16'h0, 3'b010, 2'd1, 16'h5555, 1'b1);
        applyStimulus(1'b0, 3'b010, 16'h0, 16'h5555, 16'h0, 3'b010, 2'd1, 16'h5555, 1'b1);
        applyStimulus(1'b1, 3'b010, 16'h0, 16'h5555, 16'h0, 3'b000, 2'd3, 16'h0000, 1'b0);
        applyStimulus(1'b0, 3'b111, 16'h0001, 16'h0002, 16'h0003, 3'b001, 2'd0, 16'h0001, 1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 50000000: minimum dwell of one owner on the display, in clk cycles; legal range >= 1.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  3  request per source; bit k = source k wants the display.
REQ-005 din0, din1, din2  in  16 each  value offered by source 0/1/2.
REQ-006 q_a  out  16  registered value driven to the 4-digit hex display driver.
REQ-007 gnt  out  3  registered one-hot grant; all-zero when no live grant.
REQ-008 src  out  2  current owner index 0..2; 2'b11 = no owner.
REQ-009 busy  out  1  high while an owner holds the display (state OWN).

Function
REQ-010 State machine SHALL have two states: IDLE (no owner) and OWN (owner k, dwell counter running).
REQ-011 Round-robin pointer last[1:0] SHALL record the most recent winner; search order last+1, last+2, last (mod 3).
REQ-012 IDLE: on any edge with req != 0, the winner SHALL be chosen by REQ-011, and on that same edge state -> OWN, src <= k, gnt <= one-hot(k), q_a <= din_k, counter <= 0, last <= k.
REQ-013 Latency: req rising in cycle t -> gnt, src, q_a valid in cycle t+1; no extra arbitration cycle.
REQ-014 OWN, counter < HOLD_CYC-1: counter increments each edge; owner cannot be preempted.
REQ-015 OWN with req[k]=1: q_a SHALL load din_k every edge (live tracking); gnt[k]=1.
REQ-016 OWN with req[k]=0 (owner dropped early): gnt <= 0, q_a frozen at last loaded value, src and busy unchanged, counter keeps running; re-raising req[k] before expiry restores gnt[k] and tracking.
REQ-017 Expiry edge (counter == HOLD_CYC-1): re-arbitrate using req sampled that edge; winner per REQ-011 enters OWN with counter <= 0 (zero-gap handover); if req == 0 -> IDLE.
REQ-018 Re-arbitration SHALL let the current owner win again only when no other source requests (follows from REQ-011 ordering).
REQ-019 Owner dropping req on the expiry edge itself SHALL be excluded from that arbitration.
REQ-020 IDLE: gnt=000, src=2'b11, busy=0, q_a holds last displayed value.
REQ-021 HOLD_CYC=1: re-arbitration every edge; round-robin still strict.
REQ-022 Counter width SHALL hold HOLD_CYC-1 without overflow; no wrap occurs before expiry.
REQ-023 gnt SHALL never have more than one bit set; gnt != 0 only when busy=1.

Reset
REQ-024 reset=1 at an edge SHALL force: state IDLE, q_a=16'h0000, gnt=3'b000, src=2'b11, busy=0, counter=0, last=2'd2 (source 0 highest priority first).
REQ-025 Reset SHALL override all other activity, including mid-OWN and expiry edges; first arbitration occurs on the first edge with reset=0.

Verification (HOLD_CYC=4)
REQ-026 Reset: assert reset 2 cycles with req=111 -> gnt=000, src=3, q_a=0000, busy=0 throughout.
REQ-027 Single: req=001, din0=16'h1234 in cycle 0 -> cycle 1 gnt=001, src=0, q_a=1234; change din0 to 16'hABCD -> q_a=ABCD next cycle; owner retained past expiry with no gap.
REQ-028 Contention: req=111 from IDLE, din0/1/2=0001/0002/0003 -> owners 0,1,2,0 each exactly 4 cycles, q_a following the owner.
REQ-029 Early drop: source 1 owner drops req after 1 cycle -> gnt=000, src=1, busy=1, q_a frozen for remaining 3 cycles, then IDLE (src=3) if req=0.
REQ-030 Expiry drop: owner 0 drops req exactly on expiry edge with req[2]=1 -> source 2 granted next cycle, source 0 not regranted.
REQ-031 Reset mid-OWN: reset in counter=2 of owner 1 -> next cycle reset values; after release with req=111, source 0 wins first.
